// File: rtl/life_grid_engine_if.sv
// Control/status bundle between seed/switch logic (master) and the Life engine (slave).
interface life_grid_engine_if #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
);
    logic                   on;
    logic                   step;
    logic                   load;
    logic                   wrap;
    logic [ROWS*COLS-1:0]   seed;
    logic [ROWS*COLS-1:0]   display;
    logic [GEN_W-1:0]       gen_count;
    logic                   stable;
    logic                   extinct;
    logic                   running;

    modport master (
        output on, step, load, wrap, seed,
        input  display, gen_count, stable, extinct, running
    );

    modport slave (
        input  on, step, load, wrap, seed,
        output display, gen_count, stable, extinct, running
    );
endinterface

// File: rtl/life_grid_engine.sv
// Parametrised B3/S23 Game of Life engine with toroidal/dead-edge boundary,
// rate division, single-step, seed load and stable/extinct detection.
module life_grid_engine #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int TICK_DIV       = 1,
    parameter int GEN_W          = 16,
    parameter int HALT_ON_STABLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    life_grid_engine_if.slave   bus
);
    localparam int N  = ROWS * COLS;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [TW-1:0]    tick_q,    tick_d;
    logic [N-1:0]     display_q, display_d;
    logic [GEN_W-1:0] gen_q,     gen_d;
    logic             stable_q,  stable_d;
    logic             extinct_q, extinct_d;
    logic [N-1:0]     next_grid;
    logic             advance;

    // Neighbour taps are resolved at elaboration; only edge taps depend on wrap.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            localparam int IDX = N - 1 - (gi * COLS + gj);
            logic [8:0] nb;
            logic [3:0] cnt;

            for (genvar gk = 0; gk < 9; gk++) begin : g_nb
                localparam int  DR     = gk / 3 - 1;
                localparam int  DC     = gk % 3 - 1;
                localparam int  RR     = (gi + DR + ROWS) % ROWS;
                localparam int  CC     = (gj + DC + COLS) % COLS;
                localparam bit  INSIDE = (gi + DR >= 0) && (gi + DR < ROWS) &&
                                         (gj + DC >= 0) && (gj + DC < COLS);
                if (gk == 4) begin : g_self
                    assign nb[gk] = 1'b0;
                end else if (INSIDE) begin : g_in
                    assign nb[gk] = display_q[N - 1 - (RR * COLS + CC)];
                end else begin : g_edge
                    assign nb[gk] = bus.wrap & display_q[N - 1 - (RR * COLS + CC)];
                end
            end

            always_comb begin
                cnt = '0;
                for (int k = 0; k < 9; k++) cnt = cnt + {3'b000, nb[k]};
            end

            assign next_grid[IDX] = (cnt == 4'd3) | (display_q[IDX] & (cnt == 4'd2));
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        display_d = display_q;
        gen_d     = gen_q;
        stable_d  = stable_q;
        extinct_d = extinct_q;
        advance   = 1'b0;

        if (bus.load) begin
            display_d = bus.seed;
            gen_d     = '0;
            stable_d  = 1'b0;
            extinct_d = (bus.seed == '0);
            tick_d    = '0;
            state_d   = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    advance = bus.step;
                    if (bus.on) begin
                        state_d = S_RUN;
                        tick_d  = '0;
                    end
                end
                S_RUN: begin
                    if (!bus.on) begin
                        state_d = S_IDLE;
                    end else if (tick_q == TW'(TICK_DIV - 1)) begin
                        advance = 1'b1;
                        tick_d  = '0;
                    end else begin
                        tick_d  = tick_q + TW'(1);
                    end
                end
                S_HALT: begin
                    if (!bus.on) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            if (advance) begin
                display_d = next_grid;
                gen_d     = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
                stable_d  = (next_grid == display_q);
                extinct_d = (next_grid == '0);
                if (state_q == S_RUN && HALT_ON_STABLE != 0 && next_grid == display_q)
                    state_d = S_HALT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            display_q <= '0;
            gen_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            display_q <= display_d;
            gen_q     <= gen_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
        end
    end

    assign bus.display   = display_q;
    assign bus.gen_count = gen_q;
    assign bus.stable    = stable_q;
    assign bus.extinct   = extinct_q;
    assign bus.running   = (state_q == S_RUN);
endmodule

// File: tb/tb_life_grid_engine.sv
// Directed and randomized checks of life_grid_engine against a cell-by-cell Life model.
module tb_life_grid_engine;
    localparam logic [63:0] BLINK_H = 64'h0000_7000_0000_0000;
    localparam logic [63:0] BLINK_V = 64'h0020_2020_0000_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_1818_0000_0000;
    localparam logic [63:0] CORNER  = 64'hC100_0000_0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    life_grid_engine_if #(.ROWS(8), .COLS(8), .GEN_W(16)) bus1 ();
    life_grid_engine_if #(.ROWS(8), .COLS(8), .GEN_W(3))  bus2 ();

    life_grid_engine #(.ROWS(8), .COLS(8), .TICK_DIV(1), .GEN_W(16), .HALT_ON_STABLE(1)) dut (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    life_grid_engine #(.ROWS(8), .COLS(8), .TICK_DIV(4), .GEN_W(3), .HALT_ON_STABLE(0)) dut_slow (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    // Reference: count the 8 neighbours of every cell directly from the rules.
    function automatic logic [63:0] life_ref(input logic [63:0] g, input bit wrp);
        logic [63:0] res = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrp) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                        end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
                            continue;
                        end
                        n += int'(g[63 - (rr * 8 + cc)]);
                    end
                end
                res[63 - (r * 8 + c)] = (n == 3) || (g[63 - (r * 8 + c)] && n == 2);
            end
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load1(input logic [63:0] s);
        bus1.seed = s;
        bus1.load = 1'b1;
        cyc(1);
        bus1.load = 1'b0;
    endtask

    initial begin
        logic [63:0] grid, nxt, seed;
        int          exp_gen;
        bit          w;
        int          k;

        bus1.on = 0; bus1.step = 0; bus1.load = 0; bus1.wrap = 0; bus1.seed = '0;
        bus2.on = 0; bus2.step = 0; bus2.load = 0; bus2.wrap = 0; bus2.seed = '0;
        cyc(2);
        chk("rst_display", bus1.display, 64'd0);
        chk("rst_gen", 64'(bus1.gen_count), 64'd0);
        chk("rst_stable", 64'(bus1.stable), 64'd0);
        chk("rst_extinct", 64'(bus1.extinct), 64'd0);
        chk("rst_running", 64'(bus1.running), 64'd0);
        reset = 1'b0;
        cyc(1);
        $display("[TB] reset state checked");

        // Blinker oscillation in RUN
        load1(BLINK_H);
        chk("blink_load", bus1.display, BLINK_H);
        bus1.on = 1'b1;
        cyc(1);
        chk("blink_enter_running", 64'(bus1.running), 64'd1);
        chk("blink_enter_hold", bus1.display, BLINK_H);
        cyc(1);
        chk("blink_adv1", bus1.display, BLINK_V);
        chk("blink_adv1_model", bus1.display, life_ref(BLINK_H, 1'b0));
        chk("blink_adv1_running", 64'(bus1.running), 64'd1);
        cyc(1);
        chk("blink_adv2", bus1.display, BLINK_H);
        chk("blink_adv2_gen", 64'(bus1.gen_count), 64'd2);
        chk("blink_adv2_stable", 64'(bus1.stable), 64'd0);
        chk("blink_adv2_running", 64'(bus1.running), 64'd1);
        bus1.on = 1'b0;
        cyc(1);
        $display("[TB] blinker sequence checked");

        // Block still-life halts
        load1(BLOCK);
        bus1.on = 1'b1;
        cyc(2);
        chk("block_display", bus1.display, BLOCK);
        chk("block_stable", 64'(bus1.stable), 64'd1);
        chk("block_gen", 64'(bus1.gen_count), 64'd1);
        cyc(1);
        chk("block_halted", 64'(bus1.running), 64'd0);
        chk("block_halt_gen", 64'(bus1.gen_count), 64'd1);
        bus1.on = 1'b0;
        cyc(1);
        bus1.on = 1'b1;
        cyc(1);
        chk("block_reenter_run", 64'(bus1.running), 64'd1);
        bus1.on = 1'b0;
        cyc(1);
        chk("block_run_off", 64'(bus1.running), 64'd0);
        $display("[TB] block halt checked");

        // Edge wrap via single step
        bus1.wrap = 1'b1;
        load1(CORNER);
        bus1.step = 1'b1;
        cyc(1);
        bus1.step = 1'b0;
        chk("wrap1_display", bus1.display, 64'h8080_0000_0000_0080);
        chk("wrap1_gen", 64'(bus1.gen_count), 64'd1);
        bus1.wrap = 1'b0;
        load1(CORNER);
        bus1.step = 1'b1;
        cyc(1);
        bus1.step = 1'b0;
        chk("wrap0_display", bus1.display, 64'd0);
        chk("wrap0_extinct", 64'(bus1.extinct), 64'd1);
        chk("wrap0_gen", 64'(bus1.gen_count), 64'd1);
        $display("[TB] edge wrap checked");

        // load beats step and on
        bus1.seed = BLINK_H; bus1.load = 1'b1; bus1.step = 1'b1; bus1.on = 1'b1;
        cyc(1);
        bus1.load = 1'b0; bus1.step = 1'b0;
        chk("prio_display", bus1.display, BLINK_H);
        chk("prio_gen", 64'(bus1.gen_count), 64'd0);
        chk("prio_running", 64'(bus1.running), 64'd0);
        cyc(1);
        chk("prio_then_run", 64'(bus1.running), 64'd1);
        bus1.on = 1'b0;
        cyc(1);
        $display("[TB] load priority checked");

        // Extinction in RUN halts on second empty advance
        load1(64'h0000_0008_0000_0000);
        bus1.on = 1'b1;
        cyc(2);
        chk("ext_adv1_display", bus1.display, 64'd0);
        chk("ext_adv1_extinct", 64'(bus1.extinct), 64'd1);
        chk("ext_adv1_stable", 64'(bus1.stable), 64'd0);
        chk("ext_adv1_running", 64'(bus1.running), 64'd1);
        cyc(1);
        chk("ext_adv2_stable", 64'(bus1.stable), 64'd1);
        chk("ext_adv2_gen", 64'(bus1.gen_count), 64'd2);
        chk("ext_adv2_halted", 64'(bus1.running), 64'd0);
        bus1.on = 1'b0;
        cyc(1);
        $display("[TB] extinction checked");

        // Random seeds stepped against the model
        for (int t = 0; t < 20; t++) begin
            seed = {$urandom, $urandom};
            w    = 1'($urandom_range(0, 1));
            k    = int'($urandom_range(1, 3));
            bus1.wrap = w;
            load1(seed);
            grid    = seed;
            exp_gen = 0;
            for (int s = 0; s < k; s++) begin
                nxt = life_ref(grid, w);
                bus1.step = 1'b1;
                cyc(1);
                bus1.step = 1'b0;
                exp_gen++;
                chk("rand_display", bus1.display, nxt);
                chk("rand_gen", 64'(bus1.gen_count), 64'(exp_gen));
                chk("rand_stable", 64'(bus1.stable), 64'(nxt == grid));
                chk("rand_extinct", 64'(bus1.extinct), 64'(nxt == 64'd0));
                grid = nxt;
            end
            $display("[TB] random seed %h wrap=%0d steps=%0d checked", seed, w, k);
        end

        // Divided rate and saturating counter
        bus2.seed = BLINK_H;
        bus2.load = 1'b1;
        cyc(1);
        bus2.load = 1'b0;
        bus2.on   = 1'b1;
        cyc(1);
        chk("slow_enter_running", 64'(bus2.running), 64'd1);
        for (int e = 1; e <= 36; e++) begin
            cyc(1);
            chk("slow_gen", 64'(bus2.gen_count), 64'((e / 4 > 7) ? 7 : e / 4));
            chk("slow_display", bus2.display, ((e / 4) % 2 == 1) ? BLINK_V : BLINK_H);
        end
        $display("[TB] rate division and saturation checked");

        // Asynchronous reset mid-RUN
        bus1.wrap = 1'b0;
        load1(BLINK_H);
        bus1.on = 1'b1;
        cyc(3);
        chk("pre_rst_running", 64'(bus1.running), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_display", bus1.display, 64'd0);
        chk("arst_gen", 64'(bus1.gen_count), 64'd0);
        chk("arst_running", 64'(bus1.running), 64'd0);
        chk("arst_slow_gen", 64'(bus2.gen_count), 64'd0);
        chk("arst_slow_running", 64'(bus2.running), 64'd0);
        $display("[TB] async reset checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
